pipeline_ctrl: RTL and testbench

Stall/flush sequencer for the 5-stage pipeline. Sits beside the forwarding logic and handles the hazards forwarding cannot resolve:
- load-use dependencies;
- taken-branch squashes of configurable length;
- multi-cycle data-memory waits;
- a sticky halt.

It drives the stall enables and flush (bubble-insert) strobes of the PC, IF/ID, ID/EX and EX/MEM pipeline registers.

---
 rtl/pipeline_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_pipeline_ctrl.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipeline_ctrl.sv
// rtl/pipeline_ctrl.sv - stall/flush sequencer for the 5-stage pipeline (optional perf counters: PIPE_PERF_EN)
module pipeline_ctrl #(
  parameter int REG_W        = 3,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             mem_read_ex,
  input  logic             write_reg_ex,
  input  logic [REG_W-1:0] Rd_ex,
  input  logic [REG_W-1:0] Rm_id,
  input  logic [REG_W-1:0] Rn_id,
  input  logic             use_Rm_id,
  input  logic             use_Rn_id,
  input  logic             branch_taken_ex,
  input  logic             mem_busy,
  input  logic             halt_id,
  input  logic             resume,
  output logic             stall_pc,
  output logic             stall_ifid,
  output logic             stall_idex,
  output logic             stall_exmem,
  output logic             flush_ifid,
  output logic             flush_idex,
  output logic             halted,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } state_t;

  // Remaining flush cycles loaded when a taken branch enters FLUSH; the RUN
  // cycle that sees the branch is already the first flush cycle.
  localparam logic [1:0] FCNT_INIT = 2'(FLUSH_CYCLES - 1);

  state_t     state, state_nxt;
  logic [1:0] fcnt, fcnt_nxt;
  logic       load_use;

  logic pc_s, ifid_s, idex_s, exmem_s;
  logic ifid_f, idex_f, halt_o;

  assign load_use = mem_read_ex & write_reg_ex &
                    ((use_Rm_id & (Rd_ex == Rm_id)) |
                     (use_Rn_id & (Rd_ex == Rn_id)));

  // State and flush counter register; reset aborts any sequence in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      fcnt  <= 2'd0;
    end else begin
      state <= state_nxt;
      fcnt  <= fcnt_nxt;
    end
  end

  // Next-state and raw output decode; memory waits always take precedence.
  always_comb begin
    state_nxt = state;
    fcnt_nxt  = fcnt;
    pc_s      = 1'b0;
    ifid_s    = 1'b0;
    idex_s    = 1'b0;
    exmem_s   = 1'b0;
    ifid_f    = 1'b0;
    idex_f    = 1'b0;
    halt_o    = 1'b0;
    case (state)
      RUN: begin
        if (mem_busy) begin
          pc_s      = 1'b1;
          ifid_s    = 1'b1;
          idex_s    = 1'b1;
          exmem_s   = 1'b1;
          state_nxt = MEM_WAIT;
        end else if (branch_taken_ex) begin
          ifid_f = 1'b1;
          idex_f = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            fcnt_nxt  = FCNT_INIT;
            state_nxt = FLUSH;
          end
        end else if (load_use) begin
          // The bubble in ID/EX removes the load from EX next cycle, so this
          // self-terminates after one cycle.
          pc_s   = 1'b1;
          ifid_s = 1'b1;
          idex_f = 1'b1;
        end else if (halt_id) begin
          pc_s      = 1'b1;
          ifid_s    = 1'b1;
          idex_f    = 1'b1;
          state_nxt = HALT;
        end
      end
      FLUSH: begin
        if (mem_busy) begin
          // Freeze everything, including the remaining flush count.
          pc_s    = 1'b1;
          ifid_s  = 1'b1;
          idex_s  = 1'b1;
          exmem_s = 1'b1;
        end else begin
          ifid_f   = 1'b1;
          idex_f   = 1'b1;
          fcnt_nxt = fcnt - 2'd1;
          if (fcnt <= 2'd1) begin
            state_nxt = RUN;
          end
        end
      end
      MEM_WAIT: begin
        if (mem_busy) begin
          pc_s    = 1'b1;
          ifid_s  = 1'b1;
          idex_s  = 1'b1;
          exmem_s = 1'b1;
        end else begin
          // Idle exit cycle; the frozen EX instruction is re-evaluated in RUN.
          state_nxt = RUN;
        end
      end
      HALT: begin
        if (resume) begin
          state_nxt = RUN;
        end else begin
          pc_s    = 1'b1;
          ifid_s  = 1'b1;
          idex_f  = 1'b1;
          halt_o  = 1'b1;
          exmem_s = mem_busy;
        end
      end
      default: begin
        state_nxt = RUN;
        fcnt_nxt  = 2'd0;
      end
    endcase
  end

  // Outputs are forced low for the whole time reset is held.
  assign stall_pc    = pc_s    & ~reset;
  assign stall_ifid  = ifid_s  & ~reset;
  assign stall_idex  = idex_s  & ~reset;
  assign stall_exmem = exmem_s & ~reset;
  assign flush_ifid  = ifid_f  & ~reset;
  assign flush_idex  = idex_f  & ~reset;
  assign halted      = halt_o  & ~reset;

`ifdef PIPE_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  // Saturating performance counters, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_pc && (stall_q != {CNT_W{1'b1}})) begin
        stall_q <= stall_q + CNT_W'(1);
      end
      if (flush_ifid && (flush_q != {CNT_W{1'b1}})) begin
        flush_q <= flush_q + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_q;
  assign flush_cnt = flush_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: tb/tb_pipeline_ctrl.sv
// tb/tb_pipeline_ctrl.sv - directed self-checking bench for pipeline_ctrl
module tb_pipeline_ctrl;

`ifdef PIPE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, halted}
  localparam logic [6:0] IDLE   = 7'b0000000;
  localparam logic [6:0] LU     = 7'b1100010;
  localparam logic [6:0] STALL4 = 7'b1111000;
  localparam logic [6:0] FL     = 7'b0000110;
  localparam logic [6:0] HALTO  = 7'b1100011;
  localparam logic [6:0] HALTM  = 7'b1101011;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        mem_read_ex = 1'b0, write_reg_ex = 1'b0;
  logic [2:0]  Rd_ex = 3'd0, Rm_id = 3'd0, Rn_id = 3'd0;
  logic        use_Rm_id = 1'b0, use_Rn_id = 1'b0;
  logic        branch_taken_ex = 1'b0, mem_busy = 1'b0, halt_id = 1'b0, resume = 1'b0;
  logic        stall_pc, stall_ifid, stall_idex, stall_exmem;
  logic        flush_ifid, flush_idex, halted;
  logic [15:0] stall_cnt, flush_cnt;
  logic [6:0]  obs;

  int checks = 0;
  int errors = 0;

  pipeline_ctrl dut (
    .clk(clk), .reset(reset),
    .mem_read_ex(mem_read_ex), .write_reg_ex(write_reg_ex),
    .Rd_ex(Rd_ex), .Rm_id(Rm_id), .Rn_id(Rn_id),
    .use_Rm_id(use_Rm_id), .use_Rn_id(use_Rn_id),
    .branch_taken_ex(branch_taken_ex), .mem_busy(mem_busy),
    .halt_id(halt_id), .resume(resume),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idex(stall_idex),
    .stall_exmem(stall_exmem), .flush_ifid(flush_ifid), .flush_idex(flush_idex),
    .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  assign obs = {stall_pc, stall_ifid, stall_idex, stall_exmem, flush_ifid, flush_idex, halted};

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    mem_read_ex = 1'b0; write_reg_ex = 1'b0;
    Rd_ex = 3'd0; Rm_id = 3'd0; Rn_id = 3'd0;
    use_Rm_id = 1'b0; use_Rn_id = 1'b0;
    branch_taken_ex = 1'b0; mem_busy = 1'b0; halt_id = 1'b0; resume = 1'b0;
  endtask

  task automatic do_reset();
    clear_inputs();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    clear_inputs();
    halt_id = 1'b1;
    #2;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_outputs: got %b expected %b", obs, IDLE);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    reset = 1'b0;
    halt_id = 1'b0;
    #2;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL reset_release: got %b expected %b", obs, IDLE);
    end
    tick();
  endtask

  task automatic test_load_use();
    logic [12:0] v [8];
    logic        hit [8];
    // {mem_read, write_reg, Rd, Rm, Rn, use_Rm, use_Rn}
    v   = '{13'b1_1_011_101_011_0_1, 13'b0_0_000_000_000_0_0,
            13'b1_1_011_101_011_1_0, 13'b1_1_011_011_001_1_0,
            13'b1_0_011_011_011_1_1, 13'b0_1_011_011_011_1_1,
            13'b1_1_000_000_111_1_0, 13'b1_1_110_110_110_0_0};
    hit = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    for (int i = 0; i < 8; i++) begin
      {mem_read_ex, write_reg_ex, Rd_ex, Rm_id, Rn_id, use_Rm_id, use_Rn_id} = v[i];
      #2;
      checks++;
      if (obs !== (hit[i] ? LU : IDLE)) begin
        errors++;
        $display("FAIL load_use[%0d]: got %b expected %b", i, obs, hit[i] ? LU : IDLE);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt !== (PERF ? 16'd3 : 16'd0) || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL load_use_counters: got %0d/%0d expected %0d/0", stall_cnt, flush_cnt, PERF ? 3 : 0);
    end
  endtask

  task automatic test_branch();
    logic [3:0] ci [5];
    logic [6:0] ce [5];
    // {mem_busy, branch_taken_ex, halt_id, resume}
    ci = '{4'b0100, 4'b0010, 4'b0000, 4'b0001, 4'b0000};
    ce = '{FL, FL, IDLE, IDLE, IDLE};
    do_reset();
    for (int i = 0; i < 5; i++) begin
      {mem_busy, branch_taken_ex, halt_id, resume} = ci[i];
      #2;
      checks++;
      if (obs !== ce[i]) begin
        errors++;
        $display("FAIL branch[%0d]: got %b expected %b", i, obs, ce[i]);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL branch_counters: got %0d/%0d expected 0/%0d", stall_cnt, flush_cnt, PERF ? 2 : 0);
    end
  endtask

  task automatic test_priority();
    logic [3:0] ci [10];
    logic [6:0] ce [10];
    ci = '{4'b1100, 4'b1100, 4'b1100, 4'b0100, 4'b0100, 4'b0000, 4'b0000,
           4'b0110, 4'b0000, 4'b0000};
    ce = '{STALL4, STALL4, STALL4, IDLE, FL, FL, IDLE, FL, FL, IDLE};
    do_reset();
    for (int i = 0; i < 10; i++) begin
      {mem_busy, branch_taken_ex, halt_id, resume} = ci[i];
      #2;
      checks++;
      if (obs !== ce[i]) begin
        errors++;
        $display("FAIL priority[%0d]: got %b expected %b", i, obs, ce[i]);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt !== (PERF ? 16'd3 : 16'd0) || flush_cnt !== (PERF ? 16'd4 : 16'd0)) begin
      errors++;
      $display("FAIL priority_counters: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               PERF ? 3 : 0, PERF ? 4 : 0);
    end
  endtask

  task automatic test_mem_in_flush();
    logic [3:0] ci [4];
    logic [6:0] ce [4];
    ci = '{4'b0100, 4'b1000, 4'b0000, 4'b0000};
    ce = '{FL, STALL4, FL, IDLE};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      {mem_busy, branch_taken_ex, halt_id, resume} = ci[i];
      #2;
      checks++;
      if (obs !== ce[i]) begin
        errors++;
        $display("FAIL mem_in_flush[%0d]: got %b expected %b", i, obs, ce[i]);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt !== (PERF ? 16'd1 : 16'd0) || flush_cnt !== (PERF ? 16'd2 : 16'd0)) begin
      errors++;
      $display("FAIL mem_in_flush_counters: got %0d/%0d expected %0d/%0d", stall_cnt, flush_cnt,
               PERF ? 1 : 0, PERF ? 2 : 0);
    end
  endtask

  task automatic test_halt();
    logic [3:0] ci [14];
    logic [6:0] ce [14];
    ci = '{4'b0010, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000,
           4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b1000, 4'b0001, 4'b0000};
    ce = '{LU, HALTO, HALTO, HALTO, HALTO, HALTO, HALTO, HALTO, HALTO, HALTO,
           HALTO, HALTM, IDLE, IDLE};
    do_reset();
    for (int i = 0; i < 14; i++) begin
      {mem_busy, branch_taken_ex, halt_id, resume} = ci[i];
      #2;
      checks++;
      if (obs !== ce[i]) begin
        errors++;
        $display("FAIL halt[%0d]: got %b expected %b", i, obs, ce[i]);
      end
      tick();
    end
    clear_inputs();
    checks++;
    if (stall_cnt !== (PERF ? 16'd12 : 16'd0) || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL halt_counters: got %0d/%0d expected %0d/0", stall_cnt, flush_cnt, PERF ? 12 : 0);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    halt_id = 1'b1;
    tick();
    halt_id = 1'b0;
    tick();
    #2;
    checks++;
    if (obs !== HALTO) begin
      errors++;
      $display("FAIL async_pre_halt: got %b expected %b", obs, HALTO);
    end
    reset = 1'b1;
    #1;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL async_outputs: got %b expected %b", obs, IDLE);
    end
    checks++;
    if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0) begin
      errors++;
      $display("FAIL async_counters: got %0d/%0d expected 0/0", stall_cnt, flush_cnt);
    end
    tick();
    #2;
    reset = 1'b0;
    tick();
    #2;
    checks++;
    if (obs !== IDLE) begin
      errors++;
      $display("FAIL async_run_idle: got %b expected %b", obs, IDLE);
    end
    tick();
    branch_taken_ex = 1'b1;
    #2;
    checks++;
    if (obs !== FL) begin
      errors++;
      $display("FAIL async_run_branch: got %b expected %b", obs, FL);
    end
    tick();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_branch();
    test_priority();
    test_mem_in_flush();
    test_halt();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
